// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared constants, types and helpers for the write-back stage
//
// Purpose: RV64I opcode constants, load func3 codes, NOP write-port values,
//          FSM state enum and a 32->64 sign-extension helper.
// Ports:   none (package).
package wb_pkg;

  localparam int XLEN = 64;

  // Opcodes the write-back stage distinguishes
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_NOP     = 7'b0010011;

  // Load func3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_ILL = 3'b111;

  // Register-file write port value when no write happens (addi x0,x0,0)
  localparam logic [XLEN-1:0] NOP_WDATA   = '0;
  localparam logic [4:0]      NOP_WRD     = 5'd0;
  localparam logic [6:0]      NOP_WOPCODE = OPC_NOP;

  typedef enum logic [0:0] {
    ST_IDLE      = 1'b0,
    ST_LOAD_WAIT = 1'b1
  } wb_state_e;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x);
    return {{32{x[31]}}, x[31:0]};
  endfunction

endpackage

// File: rtl/wb_unit_if.sv
// rtl/wb_unit_if.sv - handshake, memory and register-file write bundle
//
// Purpose: groups every non-clock/reset signal of the write-back stage.
// Modports:
//   master - upstream pipeline / memory / testbench side
//   slave  - wb_unit side
// Signals: flush, in_valid/in_ready, in_opcode/in_func3/in_rd,
//          in_alu_result, in_pc_plus4, dmem_req/dmem_addr,
//          dmem_rvalid/dmem_rdata, wdata/wrd/wopcode, load_misalign.
interface wb_unit_if;
  import wb_pkg::*;

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [6:0]      in_opcode;
  logic [2:0]      in_func3;
  logic [4:0]      in_rd;
  logic [XLEN-1:0] in_alu_result;
  logic [XLEN-1:0] in_pc_plus4;
  logic            dmem_req;
  logic [XLEN-1:0] dmem_addr;
  logic            dmem_rvalid;
  logic [XLEN-1:0] dmem_rdata;
  logic [XLEN-1:0] wdata;
  logic [4:0]      wrd;
  logic [6:0]      wopcode;
  logic            load_misalign;

  modport master (
    output flush, in_valid, in_opcode, in_func3, in_rd, in_alu_result,
           in_pc_plus4, dmem_rvalid, dmem_rdata,
    input  in_ready, dmem_req, dmem_addr, wdata, wrd, wopcode, load_misalign
  );

  modport slave (
    input  flush, in_valid, in_opcode, in_func3, in_rd, in_alu_result,
           in_pc_plus4, dmem_rvalid, dmem_rdata,
    output in_ready, dmem_req, dmem_addr, wdata, wrd, wopcode, load_misalign
  );

endinterface

// File: rtl/wb_load_align.sv
// rtl/wb_load_align.sv - combinational load data extraction and extension
//
// Purpose: picks the addressed lane out of a doubleword read and extends it
//          according to the load func3; flags misaligned or illegal loads.
// Ports:
//   i_rdata    - doubleword returned by data memory
//   i_func3    - load func3
//   i_off      - byte offset (address bits [2:0])
//   o_data     - extracted, extended value
//   o_misalign - access crosses its natural alignment or func3 is illegal
module wb_load_align
  import wb_pkg::*;
(
  input  logic [XLEN-1:0] i_rdata,
  input  logic [2:0]      i_func3,
  input  logic [2:0]      i_off,
  output logic [XLEN-1:0] o_data,
  output logic            o_misalign
);

  logic [XLEN-1:0] w_lane;

  // Little-endian: the addressed byte moves to bit 0
  assign w_lane = i_rdata >> {i_off, 3'b000};

  always_comb begin
    o_data = '0;
    case (i_func3)
      F3_LB:   o_data = {{56{w_lane[7]}},  w_lane[7:0]};
      F3_LH:   o_data = {{48{w_lane[15]}}, w_lane[15:0]};
      F3_LW:   o_data = {{32{w_lane[31]}}, w_lane[31:0]};
      F3_LD:   o_data = w_lane;
      F3_LBU:  o_data = {56'd0, w_lane[7:0]};
      F3_LHU:  o_data = {48'd0, w_lane[15:0]};
      F3_LWU:  o_data = {32'd0, w_lane[31:0]};
      default: o_data = '0;
    endcase
  end

  always_comb begin
    o_misalign = 1'b0;
    case (i_func3)
      F3_LH, F3_LHU: o_misalign = i_off[0];
      F3_LW, F3_LWU: o_misalign = (i_off[1:0] != 2'b00);
      F3_LD:         o_misalign = (i_off != 3'b000);
      F3_ILL:        o_misalign = 1'b1;
      default:       o_misalign = 1'b0;
    endcase
  end

endmodule

// File: rtl/wb_unit.sv
// rtl/wb_unit.sv - RV64I write-back stage driving the register-file write port
//
// Purpose: accepts one retiring instruction per handshake, reads data memory
//          for loads, selects the write-back value and emits a registered
//          one-cycle register-file write.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - wb_unit_if.slave: instruction handshake, data-memory read
//          request/response, register-file write port, load_misalign pulse
module wb_unit
  import wb_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  wb_unit_if.slave  bus
);

  localparam logic [0:0] S_IDLE      = ST_IDLE;
  localparam logic [0:0] S_LOAD_WAIT = ST_LOAD_WAIT;

  logic [0:0]      r_state;
  logic [2:0]      r_func3;
  logic [4:0]      r_rd;
  logic [2:0]      r_off;
  logic            r_dmem_req;
  logic [XLEN-1:0] r_dmem_addr;
  logic [XLEN-1:0] r_wdata;
  logic [4:0]      r_wrd;
  logic [6:0]      r_wopcode;
  logic            r_load_misalign;

  logic            w_idle;
  logic            w_accept;
  logic            w_is_load;
  logic            w_no_rd;
  logic [XLEN-1:0] w_wb_value;
  logic [XLEN-1:0] w_ld_data;
  logic            w_ld_misalign;

  assign w_idle    = (r_state == S_IDLE);
  assign w_accept  = bus.in_valid & w_idle & ~bus.flush;
  assign w_is_load = (bus.in_opcode == OPC_LOAD);
  // Stores and branches have no destination; zeroing rd keeps decode-stage
  // forwarding from matching a live register.
  assign w_no_rd   = (bus.in_opcode == OPC_STORE) | (bus.in_opcode == OPC_BRANCH);

  always_comb begin
    w_wb_value = bus.in_alu_result;
    case (bus.in_opcode)
      OPC_JAL, OPC_JALR:    w_wb_value = bus.in_pc_plus4;
      OPC_OP32, OPC_OPIMM32: w_wb_value = sext32(bus.in_alu_result);
      default:              w_wb_value = bus.in_alu_result;
    endcase
  end

  wb_load_align u_align (
    .i_rdata    (bus.dmem_rdata),
    .i_func3    (r_func3),
    .i_off      (r_off),
    .o_data     (w_ld_data),
    .o_misalign (w_ld_misalign)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= S_IDLE;
      r_func3         <= 3'd0;
      r_rd            <= 5'd0;
      r_off           <= 3'd0;
      r_dmem_req      <= 1'b0;
      r_dmem_addr     <= '0;
      r_wdata         <= NOP_WDATA;
      r_wrd           <= NOP_WRD;
      r_wopcode       <= NOP_WOPCODE;
      r_load_misalign <= 1'b0;
    end else begin
      // Write port is a one-cycle pulse: NOP unless a write fires this edge
      r_wdata         <= NOP_WDATA;
      r_wrd           <= NOP_WRD;
      r_wopcode       <= NOP_WOPCODE;
      r_load_misalign <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_load) begin
              r_func3     <= bus.in_func3;
              r_rd        <= bus.in_rd;
              r_off       <= bus.in_alu_result[2:0];
              r_dmem_req  <= 1'b1;
              r_dmem_addr <= {bus.in_alu_result[XLEN-1:3], 3'b000};
              r_state     <= S_LOAD_WAIT;
            end else begin
              r_wdata   <= w_wb_value;
              r_wrd     <= w_no_rd ? 5'd0 : bus.in_rd;
              r_wopcode <= bus.in_opcode;
            end
          end
        end

        S_LOAD_WAIT: begin
          // The pending load is older than anything offered, so flush
          // never cancels it.
          if (bus.dmem_rvalid) begin
            r_dmem_req <= 1'b0;
            r_state    <= S_IDLE;
            if (w_ld_misalign) begin
              r_load_misalign <= 1'b1;
            end else begin
              r_wdata   <= w_ld_data;
              r_wrd     <= r_rd;
              r_wopcode <= OPC_LOAD;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready      = w_idle;
  assign bus.dmem_req      = r_dmem_req;
  assign bus.dmem_addr     = r_dmem_addr;
  assign bus.wdata         = r_wdata;
  assign bus.wrd           = r_wrd;
  assign bus.wopcode       = r_wopcode;
  assign bus.load_misalign = r_load_misalign;

endmodule

// File: tb/tb_wb_unit.sv
// tb/tb_wb_unit.sv - directed self-checking bench for wb_unit
module tb_wb_unit;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  wb_unit_if bus();

  wb_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.in_valid      = 1'b0;
    bus.flush         = 1'b0;
    bus.in_opcode     = 7'b0010011;
    bus.in_func3      = 3'd0;
    bus.in_rd         = 5'd0;
    bus.in_alu_result = 64'd0;
    bus.in_pc_plus4   = 64'd0;
    bus.dmem_rvalid   = 1'b0;
    bus.dmem_rdata    = 64'd0;
  endtask

  task automatic offer(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [63:0] alu, input logic [63:0] pc4);
    bus.in_valid      = 1'b1;
    bus.in_opcode     = opc;
    bus.in_func3      = f3;
    bus.in_rd         = rd;
    bus.in_alu_result = alu;
    bus.in_pc_plus4   = pc4;
  endtask

  // Issues a load, waits the given cycles, returns #1 after the completing edge
  task automatic run_load(input logic [2:0] f3, input logic [4:0] rd, input logic [63:0] addr,
                          input logic [63:0] rdata, input int waits);
    offer(7'b0000011, f3, rd, addr, 64'd0);
    tick();
    bus.in_valid = 1'b0;
    repeat (waits) tick();
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = rdata;
    tick();
    bus.dmem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    offer(7'b0010011, 3'd0, 5'd5, 64'h99, 64'd0);
    repeat (3) tick();
    n_total++; if (bus.wdata !== 64'd0) $display("FAIL reset_wdata: got %h want 0", bus.wdata); else n_pass++;
    n_total++; if (bus.wrd !== 5'd0) $display("FAIL reset_wrd: got %0d want 0", bus.wrd); else n_pass++;
    n_total++; if (bus.wopcode !== 7'b0010011) $display("FAIL reset_wopcode: got %b want 0010011", bus.wopcode); else n_pass++;
    n_total++; if (bus.dmem_req !== 1'b0) $display("FAIL reset_dmem_req: got %b want 0", bus.dmem_req); else n_pass++;
    n_total++; if (bus.dmem_addr !== 64'd0) $display("FAIL reset_dmem_addr: got %h want 0", bus.dmem_addr); else n_pass++;
    n_total++; if (bus.load_misalign !== 1'b0) $display("FAIL reset_misalign: got %b want 0", bus.load_misalign); else n_pass++;
    quiet();
    rst = 1'b1;
    tick();
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else n_pass++;
    n_total++; if (bus.wrd !== 5'd0) $display("FAIL reset_idle_wrd: got %0d want 0", bus.wrd); else n_pass++;
  endtask

  task automatic test_back_to_back();
    offer(7'b0010011, 3'd0, 5'd5, 64'h1234, 64'd0);
    tick();
    offer(7'b1101111, 3'd0, 5'd1, 64'h5555, 64'h80);
    n_total++; if (bus.wrd !== 5'd5) $display("FAIL addi_wrd: got %0d want 5", bus.wrd); else n_pass++;
    n_total++; if (bus.wdata !== 64'h1234) $display("FAIL addi_wdata: got %h want 1234", bus.wdata); else n_pass++;
    n_total++; if (bus.wopcode !== 7'b0010011) $display("FAIL addi_wopcode: got %b want 0010011", bus.wopcode); else n_pass++;
    tick();
    bus.in_valid = 1'b0;
    n_total++; if (bus.wrd !== 5'd1) $display("FAIL jal_wrd: got %0d want 1", bus.wrd); else n_pass++;
    n_total++; if (bus.wdata !== 64'h80) $display("FAIL jal_wdata: got %h want 80", bus.wdata); else n_pass++;
    n_total++; if (bus.wopcode !== 7'b1101111) $display("FAIL jal_wopcode: got %b want 1101111", bus.wopcode); else n_pass++;
    tick();
    n_total++; if (bus.wrd !== 5'd0 || bus.wdata !== 64'd0) $display("FAIL b2b_nop: got wrd=%0d wdata=%h want 0/0", bus.wrd, bus.wdata); else n_pass++;
  endtask

  task automatic test_addw_load_wait();
    offer(7'b0111011, 3'd0, 5'd3, 64'h0000_0000_8000_0000, 64'd0);
    tick();
    bus.in_valid = 1'b0;
    n_total++; if (bus.wdata !== 64'hFFFF_FFFF_8000_0000) $display("FAIL addw_wdata: got %h want ffffffff80000000", bus.wdata); else n_pass++;
    n_total++; if (bus.wrd !== 5'd3) $display("FAIL addw_wrd: got %0d want 3", bus.wrd); else n_pass++;
    tick();
    offer(7'b0000011, 3'b000, 5'd7, 64'h1003, 64'd0);
    tick();
    bus.in_valid = 1'b0;
    n_total++; if (bus.dmem_req !== 1'b1) $display("FAIL lb_req: got %b want 1", bus.dmem_req); else n_pass++;
    n_total++; if (bus.dmem_addr !== 64'h1000) $display("FAIL lb_addr: got %h want 1000", bus.dmem_addr); else n_pass++;
    n_total++; if (bus.wrd !== 5'd0) $display("FAIL lb_nowrite: got %0d want 0", bus.wrd); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++; if (bus.in_ready !== 1'b0 || bus.dmem_req !== 1'b1 || bus.dmem_addr !== 64'h1000)
        $display("FAIL lb_wait%0d: got ready=%b req=%b addr=%h want 0/1/1000", i, bus.in_ready, bus.dmem_req, bus.dmem_addr);
      else n_pass++;
    end
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 64'h0000_0000_8100_0000;
    tick();
    bus.dmem_rvalid = 1'b0;
    n_total++; if (bus.wdata !== 64'hFFFF_FFFF_FFFF_FF81) $display("FAIL lb_wdata: got %h want ffffffffffffff81", bus.wdata); else n_pass++;
    n_total++; if (bus.wrd !== 5'd7) $display("FAIL lb_wrd: got %0d want 7", bus.wrd); else n_pass++;
    n_total++; if (bus.wopcode !== 7'b0000011) $display("FAIL lb_wopcode: got %b want 0000011", bus.wopcode); else n_pass++;
    n_total++; if (bus.dmem_req !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL lb_done: got req=%b ready=%b want 0/1", bus.dmem_req, bus.in_ready); else n_pass++;
    tick();
    n_total++; if (bus.wrd !== 5'd0) $display("FAIL lb_pulse: got %0d want 0", bus.wrd); else n_pass++;
  endtask

  task automatic test_load_variants();
    run_load(3'b101, 5'd8, 64'h2006, 64'hBEEF_0000_0000_0000, 0);
    n_total++; if (bus.wdata !== 64'h0000_0000_0000_BEEF) $display("FAIL lhu_wdata: got %h want beef", bus.wdata); else n_pass++;
    n_total++; if (bus.wrd !== 5'd8) $display("FAIL lhu_wrd: got %0d want 8", bus.wrd); else n_pass++;
    tick();
    run_load(3'b011, 5'd9, 64'h2000, 64'h0123_4567_89AB_CDEF, 1);
    n_total++; if (bus.wdata !== 64'h0123_4567_89AB_CDEF) $display("FAIL ld_wdata: got %h want 0123456789abcdef", bus.wdata); else n_pass++;
    tick();
    run_load(3'b110, 5'd11, 64'h2004, 64'hDEAD_BEEF_1234_5678, 0);
    n_total++; if (bus.wdata !== 64'h0000_0000_DEAD_BEEF) $display("FAIL lwu_wdata: got %h want deadbeef", bus.wdata); else n_pass++;
    tick();
  endtask

  task automatic test_misaligned();
    run_load(3'b010, 5'd10, 64'h3002, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    n_total++; if (bus.load_misalign !== 1'b1) $display("FAIL mis_pulse: got %b want 1", bus.load_misalign); else n_pass++;
    n_total++; if (bus.wrd !== 5'd0 || bus.wdata !== 64'd0 || bus.wopcode !== 7'b0010011)
      $display("FAIL mis_nop: got wrd=%0d wdata=%h wop=%b want 0/0/0010011", bus.wrd, bus.wdata, bus.wopcode);
    else n_pass++;
    n_total++; if (bus.dmem_req !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL mis_done: got req=%b ready=%b want 0/1", bus.dmem_req, bus.in_ready); else n_pass++;
    tick();
    n_total++; if (bus.load_misalign !== 1'b0) $display("FAIL mis_once: got %b want 0", bus.load_misalign); else n_pass++;
  endtask

  task automatic test_store_flush_reset();
    offer(7'b0100011, 3'b011, 5'd9, 64'h55, 64'd0);
    tick();
    bus.in_valid = 1'b0;
    n_total++; if (bus.wrd !== 5'd0) $display("FAIL store_wrd: got %0d want 0", bus.wrd); else n_pass++;
    n_total++; if (bus.wopcode !== 7'b0100011) $display("FAIL store_wopcode: got %b want 0100011", bus.wopcode); else n_pass++;
    n_total++; if (bus.wdata !== 64'h55) $display("FAIL store_wdata: got %h want 55", bus.wdata); else n_pass++;
    tick();
    offer(7'b0010011, 3'd0, 5'd4, 64'h77, 64'd0);
    bus.flush = 1'b1;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    n_total++; if (bus.wrd !== 5'd0 || bus.wdata !== 64'd0) $display("FAIL flush_nowrite: got wrd=%0d wdata=%h want 0/0", bus.wrd, bus.wdata); else n_pass++;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL flush_ready: got %b want 1", bus.in_ready); else n_pass++;
    offer(7'b0000011, 3'b010, 5'd12, 64'h4000, 64'd0);
    tick();
    bus.in_valid = 1'b0;
    n_total++; if (bus.dmem_req !== 1'b1) $display("FAIL rstload_req: got %b want 1", bus.dmem_req); else n_pass++;
    tick();
    #2 rst = 1'b0;
    #1;
    n_total++; if (bus.dmem_req !== 1'b0) $display("FAIL rstload_req_drop: got %b want 0", bus.dmem_req); else n_pass++;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL rstload_ready: got %b want 1", bus.in_ready); else n_pass++;
    tick();
    rst = 1'b1;
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 64'h1111_2222_3333_4444;
    tick();
    bus.dmem_rvalid = 1'b0;
    n_total++; if (bus.wrd !== 5'd0 || bus.wdata !== 64'd0 || bus.wopcode !== 7'b0010011)
      $display("FAIL rstload_ignored: got wrd=%0d wdata=%h wop=%b want 0/0/0010011", bus.wrd, bus.wdata, bus.wopcode);
    else n_pass++;
    n_total++; if (bus.dmem_req !== 1'b0) $display("FAIL rstload_idle_req: got %b want 0", bus.dmem_req); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    quiet();
    rst = 1'b0;
    test_reset();
    test_back_to_back();
    test_addw_load_wait();
    test_load_variants();
    test_misaligned();
    test_store_flush_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
